mult32x32_arbiter: RTL and testbench
====================================

Name: mult32x32_arbiter

Overview:
- Shares one 32x32 multiplier (start/busy FSM plus datapath, 4 busy cycles per operation) between two requester ports.
- Arbitrates requests, then owns the operation end to end: drives the multiplier start and operands, tracks busy, captures the 64-bit product and returns it to the winning port over a valid/ready response.
- Sits between the client blocks and the multiplier top-level; it is the only driver of the multiplier start input.

Parameters:
PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins a simultaneous request
CNT_W, 16, width of the completed-operation counter

Ports:
clk  input  1  clock, all flops on rising edge
reset  input  1  asynchronous, active-high; clears all state and outputs
req0_valid  input  1  port 0 request valid
req0_ready  output  1  port 0 request accepted this cycle
req0_a  input  32  port 0 operand A
req0_b  input  32  port 0 operand B
req1_valid  input  1  port 1 request valid
req1_ready  output  1  port 1 request accepted this cycle
req1_a  input  32  port 1 operand A
req1_b  input  32  port 1 operand B
resp0_valid  output  1  product for port 0 available
resp0_ready  input  1  port 0 consumes response
resp1_valid  output  1  product for port 1 available
resp1_ready  input  1  port 1 consumes response
resp_product  output  64  captured product, shared by both response ports
mult_start  output  1  start pulse to multiplier
mult_a  output  32  operand A to multiplier
mult_b  output  32  operand B to multiplier
mult_busy  input  1  multiplier busy indication
mult_product  input  64  multiplier product register
busy  output  1  arbiter holds an operation (state != IDLE)
op_count  output  CNT_W  completed operations; wraps modulo 2^CNT_W

Behaviour:
- Reset (async, high): state IDLE; all outputs 0; last_grant = 1, so port 0 wins the first tie. Reset mid-operation drops the operation with no response; the multiplier shares the same reset.
- States: IDLE, ISSUE, WAIT, RUN, RESP.
- IDLE:
  - Selects a winner among the valid ports.
  - Tie, PRIO_FIXED=0: winner is the port != last_grant. Tie, PRIO_FIXED=1: port 0.
  - Winner's reqN_ready = 1 combinationally in the same cycle (accept). The loser's ready stays 0.
  - On accept: register the winner's a/b into mult_a/mult_b, record grant_id, go to ISSUE.
- ISSUE: mult_start = 1 for exactly one cycle, then WAIT.
- WAIT: mult_busy = 1 goes to RUN; otherwise stay in WAIT.
- RUN: while mult_busy = 1, stay. On mult_busy = 0: resp_product <= mult_product, go to RESP.
- mult_a/mult_b hold their value from accept until the next accept; they are never changed mid-operation.
- RESP:
  - respN_valid = 1 for grant_id only.
  - Handshake when respN_ready = 1: op_count++, last_grant <= grant_id, return to IDLE.
  - While ready is low: hold resp_product and valid; accept no new request.
  - resp_product keeps its value after the handshake until the next capture.
- Latency: accept at cycle T → mult_start at T+1 → mult_busy T+2..T+5 → capture at T+6 → respN_valid at T+7.
  - Minimum issue interval 8 cycles with resp_ready tied high: accept, 7 cycles, handshake, next accept the cycle after returning to IDLE.
- Requesters hold valid and operands stable until ready. The arbiter never accepts on both ports in one cycle.
- op_count at all-ones wraps to 0 on the next completion.
- busy = 1 in ISSUE, WAIT, RUN and RESP.

Test Plan:
- Reset, then port 0 only, a=3, b=5, resp0_ready=1 → req0_ready at T, mult_start only at T+1, resp0_valid at T+7, resp_product = 64'hF, op_count = 1.
- Port 1 only, a=b=32'hFFFFFFFF → resp1_valid = 1, resp0_valid = 0, resp_product = 64'hFFFFFFFE00000001.
- PRIO_FIXED=0, both valid continuously (port 0: 0x12345678*0x10; port 1: 2*7) → grants ordered 0,1,0,1; products 0x123456780 and 0xE alternate.
- PRIO_FIXED=1, both valid continuously → port 0 granted every time, req1_ready never 1.
- Hold resp0_ready=0 for 10 cycles with req1_valid=1 → resp0_valid and product held, req1_ready stays 0; port 1 is accepted the cycle after the resp0 handshake and IDLE return.
- Assert reset during RUN → all outputs 0 immediately; the next request completes normally with correct latency. Separately, 65536 completions → op_count wraps to 0.

Source files
------------

// File: rtl/mult32x32_arbiter.sv
// Two-port front end for a shared 4-cycle 32x32 multiplier. Each accepted request
// is carried from operand issue through product capture to its response handshake.
module mult32x32_arbiter #(
  parameter bit PRIO_FIXED = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [63:0]      resp_product,
  output logic             mult_start,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  input  logic             mult_busy,
  input  logic [63:0]      mult_product,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RUN, RESP} state_t;

  state_t state, state_nxt;
  logic   grant_id, last_grant;
  logic   win, accept, resp_fire, capture;

  // win = 1 selects port 1; on a tie round-robin favours the port not served last
  always_comb begin
    win = 1'b0;
    if (req0_valid && req1_valid) begin
      win = PRIO_FIXED ? 1'b0 : ~last_grant;
    end else begin
      win = ~req0_valid;
    end
  end

  assign accept    = (state == IDLE) && (req0_valid || req1_valid);
  assign resp_fire = (state == RESP) && (grant_id ? resp1_ready : resp0_ready);
  assign capture   = (state == RUN) && !mult_busy;

  // Ready is masked by reset so every output reads 0 while reset is held
  assign req0_ready  = accept && !win && !reset;
  assign req1_ready  = accept && win && !reset;
  assign mult_start  = (state == ISSUE);
  assign busy        = (state != IDLE);
  assign resp0_valid = (state == RESP) && !grant_id;
  assign resp1_valid = (state == RESP) && grant_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mult_busy) state_nxt = RUN;
      RUN:     if (!mult_busy) state_nxt = RESP;
      RESP:    if (resp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      op_count   <= '0;
    end else begin
      if (accept) grant_id <= win;
      if (resp_fire) begin
        last_grant <= grant_id;
        op_count   <= op_count + CNT_W'(1);
      end
    end
  end

  // Operands stay frozen from accept to the next accept; product holds until next capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_a       <= '0;
      mult_b       <= '0;
      resp_product <= '0;
    end else begin
      if (accept) begin
        mult_a <= win ? req1_a : req0_a;
        mult_b <= win ? req1_b : req0_b;
      end
      if (capture) resp_product <= mult_product;
    end
  end

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Randomized bench for mult32x32_arbiter: a round-robin instance and a fixed-priority
// instance with a narrow counter, each against a cycle-timed transaction model.
module tb_mult32x32_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  r0v = '0, r1v = '0, s0r = '0, s1r = '0;
  logic [1:0]  r0rdy, r1rdy, v0, v1, ms, bz, mbusy;
  logic [31:0] a0[2], b0[2], a1[2], b1[2], ma[2], mb[2];
  logic [63:0] rp[2], mprod[2];
  logic [15:0] oc0;
  logic [3:0]  oc1;
  int          mcnt[2];

  mult32x32_arbiter #(.PRIO_FIXED(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset),
    .req0_valid(r0v[0]), .req0_ready(r0rdy[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req1_valid(r1v[0]), .req1_ready(r1rdy[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .resp0_valid(v0[0]), .resp0_ready(s0r[0]), .resp1_valid(v1[0]), .resp1_ready(s1r[0]),
    .resp_product(rp[0]), .mult_start(ms[0]), .mult_a(ma[0]), .mult_b(mb[0]),
    .mult_busy(mbusy[0]), .mult_product(mprod[0]), .busy(bz[0]), .op_count(oc0)
  );

  mult32x32_arbiter #(.PRIO_FIXED(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(r0v[1]), .req0_ready(r0rdy[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req1_valid(r1v[1]), .req1_ready(r1rdy[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .resp0_valid(v0[1]), .resp0_ready(s0r[1]), .resp1_valid(v1[1]), .resp1_ready(s1r[1]),
    .resp_product(rp[1]), .mult_start(ms[1]), .mult_a(ma[1]), .mult_b(mb[1]),
    .mult_busy(mbusy[1]), .mult_product(mprod[1]), .busy(bz[1]), .op_count(oc1)
  );

  // Multiplier stand-in: busy for the four cycles after a start pulse
  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mcnt[d]  <= 0;
        mprod[d] <= '0;
      end else if (ms[d]) begin
        mcnt[d]  <= 4;
        mprod[d] <= {32'b0, ma[d]} * {32'b0, mb[d]};
      end else if (mcnt[d] > 0) begin
        mcnt[d] <= mcnt[d] - 1;
      end
    end
  end
  assign mbusy[0] = (mcnt[0] != 0);
  assign mbusy[1] = (mcnt[1] != 0);

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: an operation is "age" cycles past its accept cycle
  bit          m_idle[2], m_gid[2], m_last[2];
  int          m_age[2], m_cnt[2];
  logic [63:0] m_prod[2], m_rp[2];
  logic [31:0] m_ma[2], m_mb[2];

  int          rate0 = 0, rate1 = 0, rrate = 100;
  bit          fix_en = 1'b0;
  logic [31:0] fa0 = '0, fb0 = '0, fa1 = '0, fb1 = '0;
  bit          clr0[2], clr1[2];

  function automatic logic [31:0] rand_op();
    case ($urandom_range(7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [63:0] cnt_mask(input int d);
    return (d == 0) ? 64'hFFFF : 64'hF;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_idle[d] = 1'b1; m_gid[d] = 1'b0; m_last[d] = 1'b1;
      m_age[d] = 0; m_cnt[d] = 0;
      m_prod[d] = '0; m_rp[d] = '0; m_ma[d] = '0; m_mb[d] = '0;
    end
  endtask

  task automatic step(input bit rst_in);
    bit have[2], w[2], bsy;
    @(negedge clk);
    reset = rst_in;
    for (int d = 0; d < 2; d++) begin
      if (clr0[d]) begin r0v[d] = 1'b0; clr0[d] = 1'b0; end
      if (clr1[d]) begin r1v[d] = 1'b0; clr1[d] = 1'b0; end
      if (!r0v[d] && $urandom_range(99) < rate0) begin
        r0v[d] = 1'b1;
        a0[d] = fix_en ? fa0 : rand_op();
        b0[d] = fix_en ? fb0 : rand_op();
      end
      if (!r1v[d] && $urandom_range(99) < rate1) begin
        r1v[d] = 1'b1;
        a1[d] = fix_en ? fa1 : rand_op();
        b1[d] = fix_en ? fb1 : rand_op();
      end
      s0r[d] = ($urandom_range(99) < rrate);
      s1r[d] = ($urandom_range(99) < rrate);
    end
    if (rst_in) model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      have[d] = !rst_in && m_idle[d] && (r0v[d] || r1v[d]);
      if (r0v[d] && r1v[d]) w[d] = (d == 1) ? 1'b0 : !m_last[d];
      else w[d] = !r0v[d];
      bsy = !rst_in && !m_idle[d];
      check_eq($sformatf("req0_ready[%0d]", d), r0rdy[d], have[d] && !w[d]);
      check_eq($sformatf("req1_ready[%0d]", d), r1rdy[d], have[d] && w[d]);
      check_eq($sformatf("mult_start[%0d]", d), ms[d], bsy && m_age[d] == 1);
      check_eq($sformatf("busy[%0d]", d), bz[d], bsy);
      check_eq($sformatf("resp0_valid[%0d]", d), v0[d], bsy && m_age[d] >= 7 && !m_gid[d]);
      check_eq($sformatf("resp1_valid[%0d]", d), v1[d], bsy && m_age[d] >= 7 && m_gid[d]);
      check_eq($sformatf("resp_product[%0d]", d), rp[d], m_rp[d]);
      check_eq($sformatf("mult_a[%0d]", d), ma[d], m_ma[d]);
      check_eq($sformatf("mult_b[%0d]", d), mb[d], m_mb[d]);
      check_eq($sformatf("op_count[%0d]", d), (d == 0) ? {48'b0, oc0} : {60'b0, oc1},
               64'(m_cnt[d]) & cnt_mask(d));
    end
    if (!rst_in) begin
      for (int d = 0; d < 2; d++) begin
        if (m_idle[d]) begin
          if (have[d]) begin
            m_idle[d] = 1'b0; m_age[d] = 1; m_gid[d] = w[d];
            m_ma[d] = w[d] ? a1[d] : a0[d];
            m_mb[d] = w[d] ? b1[d] : b0[d];
            m_prod[d] = {32'b0, m_ma[d]} * {32'b0, m_mb[d]};
            if (w[d]) clr1[d] = 1'b1; else clr0[d] = 1'b1;
          end
        end else if (m_age[d] >= 7) begin
          if (m_gid[d] ? s1r[d] : s0r[d]) begin
            m_idle[d] = 1'b1; m_cnt[d]++; m_last[d] = m_gid[d];
          end
        end else begin
          m_age[d]++;
          if (m_age[d] == 7) m_rp[d] = m_prod[d];
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
      clr0[d] = 1'b0; clr1[d] = 1'b0;
    end
    model_reset();
    step(1'b1);
    step(1'b1);

    // Single port-0 operation, 3*5
    fix_en = 1'b1; fa0 = 32'd3; fb0 = 32'd5; fa1 = 32'hFFFF_FFFF; fb1 = 32'hFFFF_FFFF;
    rate0 = 100; rate1 = 0; rrate = 100;
    step(1'b0);
    rate0 = 0;
    run(10);
    check_eq("p0_product", rp[0], 64'hF);
    check_eq("p0_count", {48'b0, oc0}, 64'd1);

    // Single port-1 operation, all-ones squared
    rate1 = 100;
    step(1'b0);
    rate1 = 0;
    run(10);
    check_eq("p1_product", rp[0], 64'hFFFF_FFFE_0000_0001);
    check_eq("p1_count", {48'b0, oc0}, 64'd2);

    // Both ports requesting continuously
    fa0 = 32'h1234_5678; fb0 = 32'h10; fa1 = 32'd2; fb1 = 32'd7;
    rate0 = 100; rate1 = 100;
    run(66);

    // Response stall on port 0 while port 1 waits
    rate0 = 0; rate1 = 0;
    run(10);
    rate0 = 100;
    step(1'b0);
    rate0 = 0; rate1 = 100; rrate = 0;
    run(17);
    rrate = 100;
    run(12);
    rate1 = 0;
    run(10);

    // Reset in the middle of RUN, then a normal operation
    fix_en = 1'b0; rate0 = 100;
    for (int i = 0; i < 20; i++) begin
      if (!m_idle[0] && m_age[0] == 4) break;
      step(1'b0);
    end
    check_eq("run_busy", bz[0], 1'b1);
    rate0 = 0;
    step(1'b1);
    step(1'b0);
    rate0 = 100;
    step(1'b0);
    rate0 = 0;
    run(12);

    // Randomized traffic with varied load and backpressure
    rate0 = 50; rate1 = 50; rrate = 60;
    run(600);
    rate0 = 30; rate1 = 80; rrate = 30;
    run(600);
    rate0 = 100; rate1 = 100; rrate = 100;
    run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
